// File: rtl/cache_pkg.sv
// Shared C2 bus command encoding, arbiter state type and sizing helper for the
// line-granular memory bus arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WDATA,
    ST_WAIT_RSP,
    ST_RDATA
  } arb_state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_picker2.sv
// Two-requester round-robin pick: the pointer only matters when both ask.
module rr_picker2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? rr_ptr : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-granular C2 memory bus between two caches;
// one line transaction at a time, responses routed only to the owning port.
module mem_bus_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int LINE_BEATS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0][1:0]        req_cmd,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_gnt,
  output logic [1:0]             req_rsp,
  output logic [DATA_W-1:0]      req_rdata,
  output logic [1:0]             mem_cmd,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_rsp,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy,
  output logic                   proto_err,
  output logic [1:0][31:0]       gnt_cnt
);

  localparam int               CNT_W     = clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);

  arb_state_t       state_reg;
  logic             rr_ptr_reg;
  logic             owner_reg;
  logic             is_write_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic [1:0]       req_vec;
  logic             pick_valid;
  logic             pick_winner;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_vec[gi] = (req_cmd[gi] != C2_NOP);
  end

  rr_picker2 u_picker (
    .req    (req_vec),
    .rr_ptr (rr_ptr_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Write beats pass straight through so the requester can advance one beat per cycle.
  always_comb begin
    mem_wdata = '0;
    if (is_write_reg && (state_reg == ST_ISSUE || state_reg == ST_WDATA))
      mem_wdata = req_wdata[owner_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= 1'b0;
      owner_reg    <= 1'b0;
      is_write_reg <= 1'b0;
      beat_cnt_reg <= '0;
      req_gnt      <= '0;
      req_rsp      <= '0;
      req_rdata    <= '0;
      mem_cmd      <= C2_NOP;
      mem_addr     <= '0;
      busy         <= 1'b0;
      proto_err    <= 1'b0;
      gnt_cnt      <= '0;
    end else begin
      req_gnt   <= '0;
      req_rsp   <= '0;
      req_rdata <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_reg            <= pick_winner;
            is_write_reg         <= (req_cmd[pick_winner] == C2_WRITE_LINE);
            mem_cmd              <= req_cmd[pick_winner];
            mem_addr             <= req_addr[pick_winner];
            req_gnt[pick_winner] <= 1'b1;
            rr_ptr_reg           <= ~pick_winner;
            gnt_cnt[pick_winner] <= gnt_cnt[pick_winner] + 32'd1;
            busy                 <= 1'b1;
            state_reg            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_cmd      <= C2_NOP;
          beat_cnt_reg <= ONE_BEAT;
          state_reg    <= is_write_reg ? ST_WDATA : ST_WAIT_RSP;
        end
        ST_WDATA: begin
          if (beat_cnt_reg == LAST_BEAT) state_reg <= ST_WAIT_RSP;
          else                           beat_cnt_reg <= beat_cnt_reg + ONE_BEAT;
        end
        ST_WAIT_RSP: begin
          if (mem_rsp) begin
            req_rsp[owner_reg] <= 1'b1;
            if (is_write_reg) begin
              busy      <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              req_rdata    <= mem_rdata;
              beat_cnt_reg <= ONE_BEAT;
              state_reg    <= ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          // A gap in the burst simply holds the count; nothing is forwarded.
          if (mem_rsp) begin
            req_rsp[owner_reg] <= 1'b1;
            req_rdata          <= mem_rdata;
            if (beat_cnt_reg == LAST_BEAT) begin
              busy      <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + ONE_BEAT;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (mem_rsp && (state_reg == ST_IDLE || state_reg == ST_ISSUE || state_reg == ST_WDATA))
        proto_err <= 1'b1;
    end
  end

endmodule
